// File: rtl/scr1_axi_mem_initiator_pkg.sv
// Shared core-memory interface types for the single-beat AXI initiator and its helpers.
package scr1_axi_mem_initiator_pkg;

  typedef enum logic {
    MemCmdRd = 1'b0,
    MemCmdWr = 1'b1
  } mem_cmd_e;

  typedef enum logic [1:0] {
    MemWidthByte    = 2'd0,
    MemWidthHword   = 2'd1,
    MemWidthWord    = 2'd2,
    MemWidthIllegal = 2'd3
  } mem_width_e;

  typedef enum logic {
    MemRespOk  = 1'b0,
    MemRespErr = 1'b1
  } mem_resp_e;

  typedef enum logic [1:0] {
    AxiRespOkay   = 2'b00,
    AxiRespExokay = 2'b01,
    AxiRespSlverr = 2'b10,
    AxiRespDecerr = 2'b11
  } axi_resp_e;

  localparam logic [1:0] AxiBurstIncr = 2'b01;

  // True when the request must be answered with an error and never reach the bus.
  function automatic logic mem_access_bad(mem_width_e width, logic [1:0] addr_lo);
    logic bad;
    unique case (width)
      MemWidthByte:    bad = 1'b0;
      MemWidthHword:   bad = addr_lo[0];
      MemWidthWord:    bad = |addr_lo;
      MemWidthIllegal: bad = 1'b1;
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic axi_resp_is_err(logic [1:0] resp);
    return (resp == AxiRespSlverr) || (resp == AxiRespDecerr);
  endfunction

endpackage

// File: rtl/scr1_axi_lane_align.sv
// Byte-lane placement for a single AXI beat: write data shift and strobes, read extract/mask.
module scr1_axi_lane_align
  import scr1_axi_mem_initiator_pkg::*;
#(
  parameter int unsigned W_DATA = 32,
  localparam int unsigned W_LANE = $clog2(W_DATA / 8)
) (
  input  logic [W_LANE-1:0]   lane,
  input  mem_width_e          width,
  input  logic [31:0]         wdata_in,
  input  logic [W_DATA-1:0]   rdata_in,
  output logic [W_DATA-1:0]   wdata_out,
  output logic [W_DATA/8-1:0] wstrb,
  output logic [31:0]         rdata_out
);

  logic [W_DATA-1:0]   wdata_ext;
  logic [W_DATA-1:0]   rdata_shift;
  logic [W_DATA/8-1:0] strb_ext;
  logic [3:0]          strb_base;
  logic [31:0]         rmask;

  always_comb begin
    unique case (width)
      MemWidthByte:  begin strb_base = 4'h1; rmask = 32'h0000_00FF; end
      MemWidthHword: begin strb_base = 4'h3; rmask = 32'h0000_FFFF; end
      MemWidthWord:  begin strb_base = 4'hF; rmask = 32'hFFFF_FFFF; end
      default:       begin strb_base = 4'h0; rmask = 32'h0000_0000; end
    endcase
  end

  always_comb begin
    wdata_ext        = '0;
    wdata_ext[31:0]  = wdata_in;
    wdata_out        = wdata_ext << {lane, 3'b000};
    strb_ext         = '0;
    strb_ext[3:0]    = strb_base;
    wstrb            = strb_ext << lane;
    rdata_shift      = rdata_in >> {lane, 3'b000};
    rdata_out        = rdata_shift[31:0] & rmask;
  end

endmodule

// File: rtl/scr1_axi_mem_initiator.sv
// Single-outstanding AXI4 initiator: one core request becomes one single-beat AXI read or write.
module scr1_axi_mem_initiator
  import scr1_axi_mem_initiator_pkg::*;
#(
  parameter int unsigned     W_ID   = 4,
  parameter int unsigned     W_ADR  = 32,
  parameter int unsigned     W_DATA = 32,
  parameter logic [W_ID-1:0] AXI_ID = '0
) (
  input  logic                clk,
  input  logic                rst,
  // Core side
  input  logic                core_req,
  output logic                core_req_ack,
  input  logic                core_cmd,
  input  logic [1:0]          core_width,
  input  logic [W_ADR-1:0]    core_addr,
  input  logic [31:0]         core_wdata,
  output logic                core_resp_vld,
  output logic [31:0]         core_rdata,
  output logic                core_resp,
  // AXI write address
  output logic                awvalid,
  input  logic                awready,
  output logic [W_ID-1:0]     awid,
  output logic [W_ADR-1:0]    awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  // AXI write data
  output logic                wvalid,
  input  logic                wready,
  output logic [W_DATA-1:0]   wdata,
  output logic [W_DATA/8-1:0] wstrb,
  output logic                wlast,
  // AXI write response
  input  logic                bvalid,
  output logic                bready,
  input  logic [W_ID-1:0]     bid,
  input  logic [1:0]          bresp,
  // AXI read address
  output logic                arvalid,
  input  logic                arready,
  output logic [W_ID-1:0]     arid,
  output logic [W_ADR-1:0]    araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  // AXI read data
  input  logic                rvalid,
  output logic                rready,
  input  logic [W_ID-1:0]     rid,
  input  logic [W_DATA-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  localparam int unsigned W_LANE = $clog2(W_DATA / 8);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddrData,
    StWrResp,
    StResp
  } state_e;

  state_e           state_q, state_d;
  mem_cmd_e         cmd_q;
  mem_width_e       width_q;
  logic [W_ADR-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [31:0]      rdata_q, rdata_d;
  mem_resp_e        resp_q, resp_d;
  logic [31:0]      rdata_ext;
  logic             accept;

  assign accept = (state_q == StIdle) && core_req;

  scr1_axi_lane_align #(
    .W_DATA (W_DATA)
  ) u_lane_align (
    .lane      (addr_q[W_LANE-1:0]),
    .width     (width_q),
    .wdata_in  (wdata_q),
    .rdata_in  (rdata),
    .wdata_out (wdata),
    .wstrb     (wstrb),
    .rdata_out (rdata_ext)
  );

  // Payload comes straight from the registered request, so it is stable while valid is held.
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, width_q};
  assign awlen   = 8'd0;
  assign awburst = AxiBurstIncr;
  assign wlast   = 1'b1;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, width_q};
  assign arlen   = 8'd0;
  assign arburst = AxiBurstIncr;

  assign core_rdata = rdata_q;
  assign core_resp  = resp_q;

  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    core_req_ack  = 1'b0;
    core_resp_vld = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;

    case (state_q)
      StIdle: begin
        core_req_ack = 1'b1;
        if (core_req) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = MemRespOk;
          if (mem_access_bad(mem_width_e'(core_width), core_addr[1:0])) begin
            resp_d  = MemRespErr;
            state_d = StResp;
          end else if (mem_cmd_e'(core_cmd) == MemCmdWr) begin
            state_d = StWrAddrData;
          end else begin
            state_d = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        arvalid = 1'b1;
        if (arready) state_d = StRdData;
      end
      StRdData: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata_ext;
          resp_d  = (axi_resp_is_err(rresp) || (rid != AXI_ID) || !rlast) ? MemRespErr
                                                                           : MemRespOk;
          state_d = StResp;
        end
      end
      StWrAddrData: begin
        // AW and W complete independently; leave once both have handshaken.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q || (awvalid && awready);
        w_done_d  = w_done_q || (wvalid && wready);
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        bready = 1'b1;
        if (bvalid) begin
          resp_d  = (axi_resp_is_err(bresp) || (bid != AXI_ID)) ? MemRespErr : MemRespOk;
          state_d = StResp;
        end
      end
      StResp: begin
        core_resp_vld = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_q     <= MemCmdRd;
      width_q   <= MemWidthByte;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= MemRespOk;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      if (accept) begin
        cmd_q   <= mem_cmd_e'(core_cmd);
        width_q <= mem_width_e'(core_width);
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
      end
    end
  end

endmodule

// File: tb/tb_scr1_axi_mem_initiator.sv
// Directed and randomized checks of the AXI initiator against a transaction-level model.
module tb_scr1_axi_mem_initiator;

  localparam int unsigned     W_ID   = 4;
  localparam int unsigned     W_ADR  = 32;
  localparam int unsigned     W_DATA = 32;
  localparam logic [W_ID-1:0] AXI_ID = 4'h3;

  logic        clk, rst;
  logic        core_req, core_req_ack, core_cmd;
  logic [1:0]  core_width;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_resp_vld, core_resp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  awid, bid, arid, rid, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  int errors = 0;
  int checks = 0;

  // Per-transaction stimulus and responder behaviour.
  logic        t_cmd;
  logic [1:0]  t_width;
  logic [31:0] t_addr, t_wdata, c_rdata;
  logic [1:0]  c_rresp, c_bresp;
  logic [3:0]  c_rid, c_bid;
  logic        c_rlast;
  int          d_aw, d_w, d_ar, d_r, d_b;

  scr1_axi_mem_initiator #(
    .W_ID   (W_ID),
    .W_ADR  (W_ADR),
    .W_DATA (W_DATA),
    .AXI_ID (AXI_ID)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_req_ack  (core_req_ack),
    .core_cmd      (core_cmd),
    .core_width    (core_width),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_resp_vld (core_resp_vld),
    .core_rdata    (core_rdata),
    .core_resp     (core_resp),
    .awvalid       (awvalid),
    .awready       (awready),
    .awid          (awid),
    .awaddr        (awaddr),
    .awsize        (awsize),
    .awlen         (awlen),
    .awburst       (awburst),
    .wvalid        (wvalid),
    .wready        (wready),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .wlast         (wlast),
    .bvalid        (bvalid),
    .bready        (bready),
    .bid           (bid),
    .bresp         (bresp),
    .arvalid       (arvalid),
    .arready       (arready),
    .arid          (arid),
    .araddr        (araddr),
    .arsize        (arsize),
    .arlen         (arlen),
    .arburst       (arburst),
    .rvalid        (rvalid),
    .rready        (rready),
    .rid           (rid),
    .rdata         (rdata),
    .rresp         (rresp),
    .rlast         (rlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_defaults();
    d_aw = 0; d_w = 0; d_ar = 0; d_r = 0; d_b = 0;
    c_rdata = '0; c_rresp = 2'b00; c_bresp = 2'b00;
    c_rid = AXI_ID; c_bid = AXI_ID; c_rlast = 1'b1;
    t_wdata = '0;
  endtask

  task automatic clear_responder();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bid = 0; bresp = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
  endtask

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Issues one request, plays the responder cycle by cycle and checks against the model.
  task automatic run_txn();
    int          lane, strb, exp_cyc, resp_cyc;
    int          aw_n, w_n, ar_n, b_n, r_n, aw_c, w_c, ar_c;
    bit          aw_ok, w_ok, ar_ok, b_ok, r_ok, got, bad, exp_err, live;
    logic [31:0] got_rdata, exp_wdata, exp_rdata;
    logic        got_resp;
    logic [3:0]  exp_wstrb;
    logic [63:0] sh, mask;

    lane      = int'(t_addr % 32'd4);
    bad       = (t_width == 2'd3) || ((t_addr % (32'd1 << t_width)) != 32'd0);
    live      = !bad;
    exp_wdata = t_wdata << (8 * lane);
    strb      = ((1 << (1 << t_width)) - 1) << lane;
    exp_wstrb = strb[3:0];
    sh        = {32'd0, c_rdata} >> (8 * lane);
    mask      = (64'd1 << (8 << t_width)) - 64'd1;
    exp_rdata = sh[31:0] & mask[31:0];
    if (bad)        exp_err = 1'b1;
    else if (t_cmd) exp_err = c_bresp[1] || (c_bid != AXI_ID);
    else            exp_err = c_rresp[1] || (c_rid != AXI_ID) || !c_rlast;
    if (bad)        exp_cyc = 1;
    else if (t_cmd) exp_cyc = 3 + imax(d_aw, d_w) + d_b;
    else            exp_cyc = 3 + d_ar + d_r;

    resp_cyc = 0; got = 0; got_rdata = '0; got_resp = 1'b0;
    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; aw_c = 0; w_c = 0; ar_c = 0;
    aw_ok = 0; w_ok = 0; ar_ok = 0; b_ok = 0; r_ok = 0;

    @(negedge clk);
    chk("idle_ack", core_req_ack, 1);
    core_req = 1; core_cmd = t_cmd; core_width = t_width;
    core_addr = t_addr; core_wdata = t_wdata;

    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        // Scramble the inputs so only the registered request can be in use.
        core_req = 0; core_cmd = ~t_cmd; core_width = 2'($urandom);
        core_addr = $urandom; core_wdata = $urandom;
        chk("busy_ack", core_req_ack, 0);
      end
      if (core_resp_vld) begin
        got = 1; resp_cyc = cyc; got_rdata = core_rdata; got_resp = core_resp;
      end
      if (awvalid) begin
        aw_n++;
        chk("aw_payload", {awaddr, awsize, awlen, awburst, awid},
            {t_addr, 1'b0, t_width, 8'd0, 2'b01, AXI_ID});
      end
      if (wvalid) begin
        w_n++;
        chk("w_payload", {wdata, wstrb, wlast}, {exp_wdata, exp_wstrb, 1'b1});
      end
      if (arvalid) begin
        ar_n++;
        chk("ar_payload", {araddr, arsize, arlen, arburst, arid},
            {t_addr, 1'b0, t_width, 8'd0, 2'b01, AXI_ID});
      end
      if (bready) b_n++;
      if (rready) r_n++;

      awready = awvalid && (aw_n > d_aw);
      if (awvalid && awready) begin aw_ok = 1; aw_c = cyc; end
      wready = wvalid && (w_n > d_w);
      if (wvalid && wready) begin w_ok = 1; w_c = cyc; end
      arready = arvalid && (ar_n > d_ar);
      if (arvalid && arready) begin ar_ok = 1; ar_c = cyc; end

      bvalid = aw_ok && w_ok && !b_ok && (cyc > imax(aw_c, w_c) + d_b);
      bid = c_bid; bresp = c_bresp;
      if (bvalid && bready) b_ok = 1;
      rvalid = ar_ok && !r_ok && (cyc > ar_c + d_r);
      rid = c_rid; rdata = c_rdata; rresp = c_rresp; rlast = c_rlast;
      if (rvalid && rready) r_ok = 1;
    end

    chk("resp_latency", resp_cyc, exp_cyc);
    chk("resp", got_resp, exp_err);
    if (!t_cmd && !bad) chk("rdata", got_rdata, exp_rdata);
    chk("aw_cycles", aw_n, (t_cmd && live) ? d_aw + 1 : 0);
    chk("w_cycles", w_n, (t_cmd && live) ? d_w + 1 : 0);
    chk("ar_cycles", ar_n, (!t_cmd && live) ? d_ar + 1 : 0);
    chk("bready_cycles", b_n, (t_cmd && live) ? d_b + 1 : 0);
    chk("rready_cycles", r_n, (!t_cmd && live) ? d_r + 1 : 0);
    chk("b_handshake", b_ok, t_cmd && live);
    chk("r_handshake", r_ok, !t_cmd && live);

    @(negedge clk);
    clear_responder();
    chk("after_resp", {core_resp_vld, core_req_ack}, 2'b01);
  endtask

  initial begin
    int w;
    rst = 1; core_req = 0; core_cmd = 0; core_width = 0; core_addr = 0; core_wdata = 0;
    clear_responder();
    set_defaults();
    t_cmd = 0; t_width = 0; t_addr = 0;
    repeat (3) @(negedge clk);
    chk("reset_out", {core_req_ack, awvalid, wvalid, bready, arvalid, rready,
                      core_resp_vld, core_resp, core_rdata}, {8'b1000_0000, 32'h0});
    rst = 0;

    // Word write, zero-wait responder
    set_defaults(); t_cmd = 1; t_width = 2; t_addr = 32'h100; t_wdata = 32'hDEAD_BEEF;
    run_txn();
    // Byte read from the top lane
    set_defaults(); t_cmd = 0; t_width = 0; t_addr = 32'h103; c_rdata = 32'hAB00_0000;
    run_txn();
    // Hword write with a slow AW channel
    set_defaults(); t_cmd = 1; t_width = 1; t_addr = 32'h102; t_wdata = 32'h0000_1234;
    d_aw = 3;
    run_txn();
    // Misaligned word read
    set_defaults(); t_cmd = 0; t_width = 2; t_addr = 32'h101;
    run_txn();
    // SLVERR on write, then wrong RID on read
    set_defaults(); t_cmd = 1; t_width = 2; t_addr = 32'h40; t_wdata = 32'h1;
    c_bresp = 2'b10;
    run_txn();
    set_defaults(); t_cmd = 0; t_width = 2; t_addr = 32'h44; c_rdata = 32'h7777_0000;
    c_rid = AXI_ID + 4'd1;
    run_txn();

    for (int n = 0; n < 40; n++) begin
      set_defaults();
      t_cmd   = 1'($urandom);
      w       = $urandom_range(0, 9);
      t_width = (w < 3) ? 2'd0 : (w < 6) ? 2'd1 : (w < 9) ? 2'd2 : 2'd3;
      t_addr  = 32'($urandom_range(0, 4095));
      if (t_width != 2'd3 && $urandom_range(0, 3) != 0)
        t_addr = t_addr & ~((32'd1 << t_width) - 32'd1);
      t_wdata = $urandom;
      c_rdata = $urandom;
      d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3);
      d_ar = $urandom_range(0, 3); d_r = $urandom_range(0, 3); d_b = $urandom_range(0, 3);
      c_bresp = 2'($urandom); c_rresp = 2'($urandom);
      if ($urandom_range(0, 7) == 0) c_bid = 4'($urandom);
      if ($urandom_range(0, 7) == 0) c_rid = 4'($urandom);
      if ($urandom_range(0, 7) == 0) c_rlast = 1'b0;
      run_txn();
    end

    // Leave non-zero read data behind, then reset in the middle of a read
    set_defaults(); t_cmd = 0; t_width = 2; t_addr = 32'h80; c_rdata = 32'h5A5A_1234;
    run_txn();
    @(negedge clk);
    core_req = 1; core_cmd = 0; core_width = 2; core_addr = 32'h200;
    @(negedge clk);
    core_req = 0;
    chk("rst_arvalid", arvalid, 1);
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("rst_rready", rready, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid", {rready, core_req_ack, core_resp_vld, arvalid, core_rdata},
        {4'b0100, 32'h0});
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", {core_resp_vld, core_req_ack}, 2'b01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
